tnoc_arbitration_requester: RTL and testbench

TNOC_ARBITRATION_REQUESTER -- requirements
Module: tnoc_arbitration_requester

---
 rtl/tnoc_requester_pkg.sv | 15 +
 rtl/tnoc_requester_fifo.sv | 66 ++++++
 rtl/tnoc_arbitration_requester.sv | 118 +++++++++++
 tb/tb_tnoc_arbitration_requester.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tnoc_requester_pkg.sv
// tnoc_requester_pkg
//   Types and constants shared by the arbitration requester and its input FIFO.
//   - req_state_e    : requester FSM states
//   - FIFO_DEPTH_MIN : smallest legal input buffer depth
package tnoc_requester_pkg;

    localparam int FIFO_DEPTH_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_GRANTED  = 2'd2
    } req_state_e;

endpackage

// File: rtl/tnoc_requester_fifo.sv
// tnoc_requester_fifo
//   Small synchronous FIFO with wrap-around read/write pointers.
//   Ports:
//     clk, rst_n     : clock, synchronous active-low reset (empties the FIFO)
//     push, wdata    : write request and entry; ignored while full, even if
//                      a pop happens in the same cycle
//     pop            : read request; ignored while empty
//     rdata          : entry at the head (valid while !empty)
//     full, empty    : occupancy flags
module tnoc_requester_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tnoc_arbitration_requester.sv
// tnoc_arbitration_requester
//   Buffers upstream flits, requests a round-robin arbiter, and forwards one
//   packet per grant. The port is released (o_free) in the cycle the tail
//   flit transfers; the next packet needs a fresh request/grant round.
//   Ports:
//     clk, rst_n                  : clock, synchronous active-low reset
//     i_valid/o_ready/i_data/i_tail : upstream flit handshake
//     o_request/i_grant/o_free     : arbiter interface
//     o_valid/i_ready/o_data/o_tail : downstream flit handshake
//     o_timeout                    : sticky grant-wait timeout flag
//   Build option: define TNOC_REQUESTER_TIMEOUT_EN to enable the grant-wait
//   counter; otherwise o_timeout is tied low.
module tnoc_arbitration_requester
    import tnoc_requester_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_tail,
    output logic                  o_request,
    input  logic                  i_grant,
    output logic                  o_free,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_tail,
    output logic                  o_timeout
);

    localparam int DEPTH = (FIFO_DEPTH < FIFO_DEPTH_MIN) ? FIFO_DEPTH_MIN : FIFO_DEPTH;

    req_state_e state_q;
    req_state_e state_d;
    logic       fifo_full;
    logic       fifo_empty;
    logic       tail_xfer;

    tnoc_requester_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_valid && o_ready),
        .wdata ({i_tail, i_data}),
        .pop   (o_valid && i_ready),
        .rdata ({o_tail, o_data}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outputs are qualified with rst_n so nothing leaks while reset is held,
    // including the cycle before the first reset edge.
    assign o_ready   = rst_n && !fifo_full;
    assign tail_xfer = o_valid && i_ready && o_tail;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (!fifo_empty) state_d = ST_REQUEST;
            ST_REQUEST: if (i_grant)     state_d = ST_GRANTED;
            ST_GRANTED: if (tail_xfer)   state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_request = 1'b0;
        o_valid   = 1'b0;
        o_free    = 1'b0;
        if (rst_n) begin
            o_request = (state_q == ST_REQUEST) || (state_q == ST_GRANTED);
            // Grant gates the beat: a dropped grant stalls without popping.
            o_valid   = (state_q == ST_GRANTED) && !fifo_empty && i_grant;
            o_free    = o_valid && i_ready && o_tail;
        end
    end

`ifdef TNOC_REQUESTER_TIMEOUT_EN
    localparam int TO_LIMIT = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_q;

    // Counts edges spent in REQUEST; the flag rises on the edge the count
    // reaches the limit and then holds until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_REQUEST) begin
            if (wait_cnt != TO_W'(TO_LIMIT)) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == TO_W'(TO_LIMIT - 1)) timeout_q <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_tnoc_arbitration_requester.sv
module tb_tnoc_arbitration_requester;

`ifdef TNOC_REQUESTER_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        i_tail;
    logic        o_request;
    logic        i_grant;
    logic        o_free;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_tail;
    logic        o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tnoc_arbitration_requester #(
        .DATA_WIDTH     (32),
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_tail    (i_tail),
        .o_request (o_request),
        .i_grant   (i_grant),
        .o_free    (o_free),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_tail    (o_tail),
        .o_timeout (o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_tail = 1'b0;
        i_grant = 1'b0; i_ready = 1'b0;

        // Reset held
        tick(); tick(); #1;
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_request", 32'(o_request), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_free", 32'(o_free), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        tick(); rst_n = 1'b1; #1;
        chk("post_rst_ready", 32'(o_ready), 1);
        chk("post_rst_request", 32'(o_request), 0);

        // 3-flit packet, grant two cycles after request
        tick(); i_valid = 1; i_data = 32'h11; i_tail = 0; i_ready = 1; #1;
        chk("a_idle_req", 32'(o_request), 0);
        tick(); i_data = 32'h22; #1;
        chk("a_idle_req2", 32'(o_request), 0);
        chk("a_ready_one", 32'(o_ready), 1);
        tick(); i_valid = 0; #1;
        chk("a_request", 32'(o_request), 1);
        chk("a_full", 32'(o_ready), 0);
        chk("a_no_valid_req", 32'(o_valid), 0);
        tick(); #1;
        chk("a_request_hold", 32'(o_request), 1);
        tick(); i_grant = 1; #1;
        chk("a_valid_before_granted", 32'(o_valid), 0);
        tick(); i_valid = 1; i_data = 32'h33; i_tail = 1; #1;
        chk("a_beat1_valid", 32'(o_valid), 1);
        chk("a_beat1_data", o_data, 32'h11);
        chk("a_beat1_free", 32'(o_free), 0);
        chk("a_full_pop_ready", 32'(o_ready), 0);
        tick(); #1;
        chk("a_beat2_valid", 32'(o_valid), 1);
        chk("a_beat2_data", o_data, 32'h22);
        chk("a_beat2_tail", 32'(o_tail), 0);
        chk("a_beat2_ready", 32'(o_ready), 1);
        tick(); i_valid = 0; #1;
        chk("a_beat3_valid", 32'(o_valid), 1);
        chk("a_beat3_data", o_data, 32'h33);
        chk("a_beat3_tail", 32'(o_tail), 1);
        chk("a_beat3_free", 32'(o_free), 1);
        tick(); i_grant = 0; #1;
        chk("a_after_request", 32'(o_request), 0);
        chk("a_after_valid", 32'(o_valid), 0);
        chk("a_after_free", 32'(o_free), 0);

        // Single flit, grant held high
        tick(); i_valid = 1; i_data = 32'hA5; i_tail = 1; i_grant = 1; #1;
        chk("b_idle_req", 32'(o_request), 0);
        tick(); i_valid = 0; #1;
        chk("b_idle_valid", 32'(o_valid), 0);
        chk("b_idle_free", 32'(o_free), 0);
        tick(); #1;
        chk("b_request", 32'(o_request), 1);
        chk("b_req_valid", 32'(o_valid), 0);
        tick(); #1;
        chk("b_valid", 32'(o_valid), 1);
        chk("b_data", o_data, 32'hA5);
        chk("b_tail", 32'(o_tail), 1);
        chk("b_free", 32'(o_free), 1);
        tick(); i_grant = 0; #1;
        chk("b_after_request", 32'(o_request), 0);
        chk("b_after_free", 32'(o_free), 0);

        // Fill with i_ready low, then grant stall for three cycles
        tick(); i_ready = 0; i_valid = 1; i_data = 32'h41; i_tail = 0; #1;
        chk("c_ready0", 32'(o_ready), 1);
        tick(); i_data = 32'h42; #1;
        chk("c_ready1", 32'(o_ready), 1);
        tick(); i_data = 32'h43; i_tail = 1; i_grant = 1; #1;
        chk("c_full", 32'(o_ready), 0);
        chk("c_req_valid", 32'(o_valid), 0);
        tick(); i_ready = 1; #1;
        chk("c_beat1_data", o_data, 32'h41);
        chk("c_beat1_valid", 32'(o_valid), 1);
        chk("c_pop_full_ready", 32'(o_ready), 0);
        tick(); i_grant = 0; #1;
        chk("c_stall1_valid", 32'(o_valid), 0);
        chk("c_stall1_free", 32'(o_free), 0);
        tick(); i_valid = 0; #1;
        chk("c_stall2_valid", 32'(o_valid), 0);
        chk("c_stall2_request", 32'(o_request), 1);
        tick(); #1;
        chk("c_stall3_valid", 32'(o_valid), 0);
        tick(); i_grant = 1; #1;
        chk("c_beat2_valid", 32'(o_valid), 1);
        chk("c_beat2_data", o_data, 32'h42);
        chk("c_beat2_free", 32'(o_free), 0);
        tick(); #1;
        chk("c_beat3_data", o_data, 32'h43);
        chk("c_beat3_free", 32'(o_free), 1);
        tick(); i_grant = 0; #1;
        chk("c_after_request", 32'(o_request), 0);

        // Grant withheld: timeout after 8 REQUEST edges when enabled
        tick(); i_valid = 1; i_data = 32'h55; i_tail = 1; #1;
        tick(); i_valid = 0; #1;
        tick(); #1;
        chk("d_request", 32'(o_request), 1);
        chk("d_timeout_start", 32'(o_timeout), 0);
        for (int k = 0; k < 7; k++) tick();
        chk("d_timeout_7", 32'(o_timeout), 0);
        tick();
        chk("d_timeout_8", 32'(o_timeout), 32'(TO_EXP));
        tick(); tick();
        chk("d_timeout_sticky", 32'(o_timeout), 32'(TO_EXP));
        chk("d_fsm_unaffected", 32'(o_request), 1);
        i_grant = 1;
        tick(); #1;
        chk("d_valid", 32'(o_valid), 1);
        chk("d_data", o_data, 32'h55);
        chk("d_free", 32'(o_free), 1);
        tick(); i_grant = 0; #1;
        chk("d_timeout_after", 32'(o_timeout), 32'(TO_EXP));
        chk("d_after_request", 32'(o_request), 0);

        // Reset mid-packet drops buffered flits without o_free
        tick(); i_ready = 0; i_valid = 1; i_data = 32'h66; i_tail = 1; #1;
        tick(); i_data = 32'h67; #1;
        tick(); i_valid = 0; i_grant = 1; #1;
        tick(); #1;
        chk("e_granted_valid", 32'(o_valid), 1);
        chk("e_granted_data", o_data, 32'h66);
        chk("e_granted_free", 32'(o_free), 0);
        rst_n = 0; i_ready = 1; #1;
        chk("e_rst_free", 32'(o_free), 0);
        chk("e_rst_valid", 32'(o_valid), 0);
        chk("e_rst_request", 32'(o_request), 0);
        chk("e_rst_ready", 32'(o_ready), 0);
        tick(); rst_n = 1; #1;
        chk("e_post_request", 32'(o_request), 0);
        chk("e_post_valid", 32'(o_valid), 0);
        chk("e_post_free", 32'(o_free), 0);
        chk("e_post_ready", 32'(o_ready), 1);
        chk("e_post_timeout", 32'(o_timeout), 0);
        tick(); #1;
        chk("e_fifo_empty_request", 32'(o_request), 0);
        chk("e_fifo_empty_valid", 32'(o_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
